// File: rtl/aes_pkg.sv
// AES shared definitions: word type, FSM state codes, Rcon table and S-box.
// Used by both the forward and the inverse key expanders.
package aes_pkg;

  localparam int AES_NR = 10;

  typedef logic [31:0] word_t;

  // FSM state codes (ST_CALC is only reached when AES_INV_KEY_PIPE_EN is defined)
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_OUT  = 2'd1;
  localparam logic [1:0] ST_CALC = 2'd2;

  localparam logic [7:0] RCON [1:10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

  // Rounds outside 1..10 never reach the datapath output; return 0 for them
  function automatic logic [7:0] rcon(input logic [3:0] r);
    if (r >= 4'd1 && r <= 4'd10) return RCON[r];
    return 8'h00;
  endfunction

endpackage

// File: rtl/aes_sub_word.sv
// SubWord: four parallel S-box lookups on a 32-bit word, purely combinational.
module aes_sub_word
  import aes_pkg::*;
(
  input  word_t word_i,
  output word_t word_o
);

  for (genvar i = 0; i < 4; i++) begin : g_byte
    assign word_o[8*i +: 8] = sbox(word_i[8*i +: 8]);
  end

endmodule

// File: rtl/aes_inv_key_expander.sv
// AES-128 inverse key schedule: accepts round key 10 and walks back to round
// key 0, one key per output handshake.
// Build option: define AES_INV_KEY_PIPE_EN to register the SubWord result and
// spend two cycles per round key (adds the CALC state).
module aes_inv_key_expander
  import aes_pkg::*;
#(
  parameter int NR = AES_NR,
  parameter int KW = 128
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [KW-1:0] in_key,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [KW-1:0] out_key,
  output logic [3:0]    out_round,
  output logic          done
);

  logic [1:0]    state_q, state_d;
  logic [KW-1:0] key_q, key_d;
  logic [3:0]    round_q, round_d;
  logic          done_q, done_d;

  word_t k0, k1, k2, k3;
  word_t p0, p1, p2, p3;
  word_t rot, sw;
  word_t rcon_w;

  assign k0 = key_q[127:96];
  assign k1 = key_q[95:64];
  assign k2 = key_q[63:32];
  assign k3 = key_q[31:0];

  // Undo the forward chaining: each word is the XOR of its neighbours
  assign p3 = k3 ^ k2;
  assign p2 = k2 ^ k1;
  assign p1 = k1 ^ k0;

  assign rot    = {p3[23:0], p3[31:24]};
  assign rcon_w = {rcon(round_q), 24'h0};

  aes_sub_word u_sub (
    .word_i (rot),
    .word_o (sw)
  );

  assign p0 = k0 ^ sw ^ rcon_w;

  wire hs_out = (state_q == ST_OUT) && out_ready;

`ifdef AES_INV_KEY_PIPE_EN
  word_t       sw_q;
  logic [95:0] pw_q;

  // Capture SubWord output and the cheap XOR words on a round>0 handshake
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sw_q <= '0;
      pw_q <= '0;
    end else if (hs_out && round_q != 4'd0) begin
      sw_q <= sw;
      pw_q <= {p1, p2, p3};
    end
  end
`endif

  // Next-state logic for the walk through rounds NR..0
  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    round_d = round_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          key_d   = in_key;
          round_d = 4'(NR);
          state_d = ST_OUT;
        end
      end
      ST_OUT: begin
        if (hs_out) begin
          if (round_q == 4'd0) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
`ifdef AES_INV_KEY_PIPE_EN
            state_d = ST_CALC;
`else
            key_d   = {p0, p1, p2, p3};
            round_d = round_q - 4'd1;
`endif
          end
        end
      end
`ifdef AES_INV_KEY_PIPE_EN
      ST_CALC: begin
        // key_q and round_q are unchanged since the handshake, so k0/rcon still apply
        key_d   = {k0 ^ sw_q ^ rcon_w, pw_q};
        round_d = round_q - 4'd1;
        state_d = ST_OUT;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      key_q   <= '0;
      round_q <= 4'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      round_q <= round_d;
      done_q  <= done_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_OUT);
  assign out_key   = key_q;
  assign out_round = round_q;
  assign done      = done_q;

endmodule
